// File: rtl/alu_pkg.sv
// Shared types for the ALU issue block: opcode encoding, command record,
// output-register states and the default command FIFO depth.
package alu_pkg;

  localparam int DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    SLL2 = 3'd2,
    SRL2 = 3'd3,
    AND  = 3'd4,
    OR   = 3'd5,
    XOR  = 3'd6,
    EQ   = 3'd7
  } opcode_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    opcode_e    op;
    logic       acc;
  } cmd_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } out_st_e;

endpackage

// File: rtl/alu_issue_if.sv
// Command / ALU / result signal bundle for alu_issue.
// slave = the issue block, master = whoever feeds commands, hosts the ALU
// and consumes results.
interface alu_issue_if
  import alu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [7:0]    cmd_a_i;
  logic [7:0]    cmd_b_i;
  logic [2:0]    cmd_op_i;
  logic          cmd_acc_i;
  logic [7:0]    alu_a_o;
  logic [7:0]    alu_b_o;
  logic [2:0]    alu_op_o;
  logic [7:0]    alu_res_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [7:0]    res_data_o;
  logic          res_zero_o;
  logic [CW-1:0] count_o;

  modport slave (
    input  cmd_valid_i, cmd_a_i, cmd_b_i, cmd_op_i, cmd_acc_i, alu_res_i, res_ready_i,
    output cmd_ready_o, alu_a_o, alu_b_o, alu_op_o, res_valid_o, res_data_o, res_zero_o, count_o
  );

  modport master (
    output cmd_valid_i, cmd_a_i, cmd_b_i, cmd_op_i, cmd_acc_i, alu_res_i, res_ready_i,
    input  cmd_ready_o, alu_a_o, alu_b_o, alu_op_o, res_valid_o, res_data_o, res_zero_o, count_o
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two), wrapping pointers, occupancy
// counter. No bypass: ready depends on occupancy only, never on pop.
// Head reads as all-zero when empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  cmd_t                     wdata,
  output cmd_t                     head,
  output logic                     empty,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  // storage write; entries need no reset because the head is masked when empty
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // pointers wrap naturally at DEPTH; occupancy holds on simultaneous push+pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign empty = (count == '0);
  assign ready = reset_n && (count < CW'(DEPTH));
  assign head  = empty ? '0 : mem[rptr];

endmodule

// File: rtl/alu_issue.sv
// ALU issue block: queues commands, presents the FIFO head to an external
// combinational ALU and captures its result into a two-state output register.
// Optional feature macro: ALU_ISSUE_ACC_CHAIN_EN -- adds an accumulator that
// loads every issued result and can replace operand A (per-command acc bit).
module alu_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_issue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  cmd_t          wcmd, head;
  logic          push, issue, fifo_empty, fifo_ready;
  logic [CW-1:0] count;
  out_st_e       st;
  logic [7:0]    res_q;
  logic          zero_q;

  assign wcmd.a  = bus.cmd_a_i;
  assign wcmd.b  = bus.cmd_b_i;
  assign wcmd.op = opcode_e'(bus.cmd_op_i);
`ifdef ALU_ISSUE_ACC_CHAIN_EN
  assign wcmd.acc = bus.cmd_acc_i;
`else
  assign wcmd.acc = 1'b0;
`endif

  assign push  = bus.cmd_valid_i && fifo_ready;
  // a held result may be replaced in the same cycle it is consumed
  assign issue = !fifo_empty && ((st == ST_EMPTY) || bus.res_ready_i);

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (issue),
    .wdata   (wcmd),
    .head    (head),
    .empty   (fifo_empty),
    .ready   (fifo_ready),
    .count   (count)
  );

`ifdef ALU_ISSUE_ACC_CHAIN_EN
  logic [7:0] acc_q;

  // accumulator follows every issued result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   acc_q <= '0;
    else if (issue) acc_q <= bus.alu_res_i;
  end

  assign bus.alu_a_o = head.acc ? acc_q : head.a;
`else
  logic unused_acc;
  assign unused_acc  = head.acc ^ bus.cmd_acc_i;
  assign bus.alu_a_o = head.a;
`endif

  assign bus.alu_b_o  = head.b;
  assign bus.alu_op_o = head.op;

  // output register: capture on issue, return to EMPTY when consumed with nothing behind it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st     <= ST_EMPTY;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else if (issue) begin
      st     <= ST_HOLD;
      res_q  <= bus.alu_res_i;
      zero_q <= (bus.alu_res_i == 8'd0);
    end else if ((st == ST_HOLD) && bus.res_ready_i) begin
      st <= ST_EMPTY;
    end
  end

  assign bus.res_valid_o = (st == ST_HOLD);
  assign bus.res_data_o  = res_q;
  assign bus.res_zero_o  = zero_q;
  assign bus.cmd_ready_o = fifo_ready;
  assign bus.count_o     = count;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus a random phase, all results
// checked against an in-order queue model with its own ALU/accumulator.
module tb_alu_issue;
  import alu_pkg::*;

  localparam int DEPTH = 4;
`ifdef ALU_ISSUE_ACC_CHAIN_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_issue_if #(.DEPTH(DEPTH)) bus ();
  alu_issue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  // external ALU model
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a << 2;
      3'd3:    return a >> 2;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  assign bus.alu_res_i = alu_f(bus.alu_a_o, bus.alu_b_o, bus.alu_op_o);

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_res = 0;
  logic [7:0] exp_q[$];
  logic [7:0] acc_m = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: drive, score any result handshake, model any accepted command
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic acc, input logic rr);
    logic [7:0] ea, r;
    bus.cmd_valid_i = v;
    bus.cmd_a_i     = a;
    bus.cmd_b_i     = b;
    bus.cmd_op_i    = op;
    bus.cmd_acc_i   = acc;
    bus.res_ready_i = rr;
    #1;
    if (bus.res_valid_o && rr) begin
      chk("res_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        chk("res_data", 32'(bus.res_data_o), 32'(r));
        chk("res_zero", 32'(bus.res_zero_o), 32'(r == 8'd0));
        n_res++;
      end
    end
    if (v && bus.cmd_ready_o) begin
      ea = a;
      if (ACC_EN && acc) ea = acc_m;
      r = alu_f(ea, b, op);
      acc_m = r;
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_cmd(input logic v, input logic rr, input logic acc);
    cycle(v, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), acc, rr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    logic [7:0] held;
    reset_n         = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_a_i     = '0;
    bus.cmd_b_i     = '0;
    bus.cmd_op_i    = '0;
    bus.cmd_acc_i   = 1'b0;
    bus.res_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_valid", 32'(bus.res_valid_o), 32'd0);
    chk("rst_data",  32'(bus.res_data_o), 32'd0);
    chk("rst_zero",  32'(bus.res_zero_o), 32'd0);
    chk("rst_alu",   32'({bus.alu_a_o, bus.alu_b_o, bus.alu_op_o}), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(bus.cmd_ready_o), 32'd1);

    // 3 + 5, two-cycle latency
    cycle(1'b1, 8'd3, 8'd5, ADD, 1'b0, 1'b0);
    chk("lat_c1_valid", 32'(bus.res_valid_o), 32'd0);
    chk("lat_c1_count", 32'(bus.count_o), 32'd1);
    cycle(1'b0, 8'd0, 8'd0, ADD, 1'b0, 1'b0);
    chk("lat_c2_valid", 32'(bus.res_valid_o), 32'd1);
    chk("add_data", 32'(bus.res_data_o), 32'd8);
    chk("add_zero", 32'(bus.res_zero_o), 32'd0);
    cycle(1'b0, 8'd0, 8'd0, ADD, 1'b0, 1'b1);
    chk("add_consumed", 32'(bus.res_valid_o), 32'd0);
    chk("empty_alu_zero", 32'({bus.alu_a_o, bus.alu_b_o, bus.alu_op_o}), 32'd0);

    // back-pressure: fill HOLD plus all FIFO entries
    for (int i = 0; i < 5; i++) rnd_cmd(1'b1, 1'b0, 1'b0);
    chk("full_count", 32'(bus.count_o), 32'(DEPTH));
    chk("full_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("full_valid", 32'(bus.res_valid_o), 32'd1);
    held = bus.res_data_o;
    chk("full_head_data", 32'(held), 32'(exp_q[0]));
    for (int i = 0; i < 3; i++) begin
      rnd_cmd(1'b1, 1'b0, 1'b0);
      chk("stall_data_stable", 32'(bus.res_data_o), 32'(held));
      chk("stall_count", 32'(bus.count_o), 32'(DEPTH));
    end

    // full FIFO with a pop in the same cycle still refuses commands
    bus.cmd_valid_i = 1'b1;
    bus.res_ready_i = 1'b1;
    #1;
    chk("full_no_bypass", 32'(bus.cmd_ready_o), 32'd0);

    // drain one per cycle
    for (int i = 0; i < 5; i++) begin
      chk("drain_valid", 32'(bus.res_valid_o), 32'd1);
      cycle(1'b0, 8'd0, 8'd0, ADD, 1'b0, 1'b1);
      chk("drain_count", 32'(bus.count_o), 32'((i < 4) ? 3 - i : 0));
    end
    chk("drain_done_valid", 32'(bus.res_valid_o), 32'd0);
    chk("drain_model_empty", 32'(exp_q.size()), 32'd0);

    // streaming, no bubbles
    base = n_res;
    for (int i = 0; i < 10; i++) begin
      rnd_cmd(1'b1, 1'b1, 1'b0);
      chk("stream_count", 32'(bus.count_o), 32'd1);
      if (i >= 1) chk("stream_nobubble", 32'(bus.res_valid_o), 32'd1);
    end
    cycle(1'b0, 8'd0, 8'd0, ADD, 1'b0, 1'b1);
    chk("stream_tail_valid", 32'(bus.res_valid_o), 32'd1);
    cycle(1'b0, 8'd0, 8'd0, ADD, 1'b0, 1'b1);
    chk("stream_end_valid", 32'(bus.res_valid_o), 32'd0);
    chk("stream_results", 32'(n_res - base), 32'd10);

    // 7 - 7 -> zero flag
    cycle(1'b1, 8'd7, 8'd7, SUB, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 8'd0, ADD, 1'b0, 1'b0);
    chk("sub_valid", 32'(bus.res_valid_o), 32'd1);
    chk("sub_data", 32'(bus.res_data_o), 32'd0);
    chk("sub_zero", 32'(bus.res_zero_o), 32'd1);
    cycle(1'b0, 8'd0, 8'd0, ADD, 1'b0, 1'b1);

    // accumulator chain: 2+3, then acc+4
    cycle(1'b1, 8'd2, 8'd3, ADD, 1'b0, 1'b1);
    cycle(1'b1, 8'hA5, 8'd4, ADD, 1'b1, 1'b1);
    chk("chain_first", 32'(bus.res_data_o), 32'd5);
    cycle(1'b0, 8'd0, 8'd0, ADD, 1'b0, 1'b1);
    chk("chain_second", 32'(bus.res_data_o), ACC_EN ? 32'd9 : 32'hA9);
    cycle(1'b0, 8'd0, 8'd0, ADD, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1 && ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
            3'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 9) < 7);
      chk("ready_rule", 32'(bus.cmd_ready_o), 32'(bus.count_o < DEPTH));
    end
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) cycle(1'b0, 8'd0, 8'd0, ADD, 1'b0, 1'b1);
    chk("random_drained", 32'(exp_q.size()), 32'd0);
    chk("random_end_valid", 32'(bus.res_valid_o), 32'd0);

    // reset with work queued
    for (int i = 0; i < 4; i++) rnd_cmd(1'b1, 1'b0, 1'b0);
    chk("preq_count", 32'(bus.count_o), 32'd3);
    chk("preq_valid", 32'(bus.res_valid_o), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_count", 32'(bus.count_o), 32'd0);
    chk("midrst_valid", 32'(bus.res_valid_o), 32'd0);
    chk("midrst_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("midrst_data",  32'(bus.res_data_o), 32'd0);
    exp_q.delete();
    acc_m = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("midrst_ready_after", 32'(bus.cmd_ready_o), 32'd1);
    // acc-based probe: accumulator must be back to 0
    cycle(1'b1, 8'h55, 8'd0, ADD, 1'b1, 1'b1);
    cycle(1'b0, 8'd0, 8'd0, ADD, 1'b0, 1'b1);
    chk("acc_after_rst", 32'(bus.res_data_o), ACC_EN ? 32'd0 : 32'h55);
    cycle(1'b0, 8'd0, 8'd0, ADD, 1'b0, 1'b1);
    chk("final_model_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
